// File: rtl/mandel_iter_mult_client.sv
// Mandelbrot pixel iterator (z <- z^2 + c) that time-shares one external multiplier
// over a val/rdy request/response interface, with a single request outstanding.
module mandel_iter_mult_client #(
  parameter int unsigned WIDTH  = 27,
  parameter int unsigned FRAC   = 23,
  parameter int unsigned ITER_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  c_re,
  input  logic [WIDTH-1:0]  c_im,
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_count,
  output logic              escaped,
  output logic [WIDTH-1:0]  mult_a,
  output logic [WIDTH-1:0]  mult_b,
  output logic              mult_in_val,
  input  logic              mult_in_rdy,
  input  logic [WIDTH-1:0]  mult_out,
  input  logic              mult_out_val,
  output logic              mult_out_rdy
);

  typedef enum logic [3:0] {
    StIdle,
    StReqXx,
    StWaitXx,
    StReqYy,
    StWaitYy,
    StReqXy,
    StWaitXy,
    StCheck,
    StDone
  } state_e;

  // Escape threshold 4.0 in the (WIDTH+1)-bit magnitude domain.
  localparam logic signed [WIDTH:0] EscLimit =
      {{(WIDTH - FRAC - 2){1'b0}}, 3'b100, {FRAC{1'b0}}};
  localparam logic [ITER_W-1:0] IterOne = 1;

  state_e            state_q;
  logic [WIDTH-1:0]  x_q, y_q, cr_q, ci_q;
  logic [WIDTH-1:0]  xx_q, yy_q, xy_q;
  logic [ITER_W-1:0] max_q;

  logic signed [WIDTH:0] mag_sq;
  logic                  escape;
  logic [WIDTH-1:0]      x_next, y_next;
  logic [ITER_W-1:0]     iter_inc;

  // Escape test and next-z arithmetic. The wrapped WIDTH-bit results equal the low
  // bits of the WIDTH+2-bit exact sums, so the update is computed modulo 2^WIDTH.
  always_comb begin
    mag_sq   = $signed({xx_q[WIDTH-1], xx_q}) + $signed({yy_q[WIDTH-1], yy_q});
    escape   = (mag_sq > EscLimit);
    x_next   = xx_q - yy_q + cr_q;
    y_next   = (xy_q << 1) + ci_q;
    iter_inc = iter_count + IterOne;
  end

  // Control FSM; all outputs are registered so async reset clears them at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      cr_q         <= '0;
      ci_q         <= '0;
      xx_q         <= '0;
      yy_q         <= '0;
      xy_q         <= '0;
      max_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      iter_count   <= '0;
      escaped      <= 1'b0;
      mult_a       <= '0;
      mult_b       <= '0;
      mult_in_val  <= 1'b0;
      mult_out_rdy <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cr_q       <= c_re;
            ci_q       <= c_im;
            max_q      <= max_iter;
            x_q        <= '0;
            y_q        <= '0;
            iter_count <= '0;
            escaped    <= 1'b0;
            busy       <= 1'b1;
            if (max_iter == '0) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              mult_a      <= '0;
              mult_b      <= '0;
              mult_in_val <= 1'b1;
              state_q     <= StReqXx;
            end
          end
        end
        StReqXx: begin
          if (mult_in_rdy) begin
            mult_in_val  <= 1'b0;
            mult_out_rdy <= 1'b1;
            state_q      <= StWaitXx;
          end
        end
        StWaitXx: begin
          if (mult_out_val) begin
            xx_q         <= mult_out;
            mult_out_rdy <= 1'b0;
            mult_a       <= y_q;
            mult_b       <= y_q;
            mult_in_val  <= 1'b1;
            state_q      <= StReqYy;
          end
        end
        StReqYy: begin
          if (mult_in_rdy) begin
            mult_in_val  <= 1'b0;
            mult_out_rdy <= 1'b1;
            state_q      <= StWaitYy;
          end
        end
        StWaitYy: begin
          if (mult_out_val) begin
            yy_q         <= mult_out;
            mult_out_rdy <= 1'b0;
            mult_a       <= x_q;
            mult_b       <= y_q;
            mult_in_val  <= 1'b1;
            state_q      <= StReqXy;
          end
        end
        StReqXy: begin
          if (mult_in_rdy) begin
            mult_in_val  <= 1'b0;
            mult_out_rdy <= 1'b1;
            state_q      <= StWaitXy;
          end
        end
        StWaitXy: begin
          if (mult_out_val) begin
            xy_q         <= mult_out;
            mult_out_rdy <= 1'b0;
            state_q      <= StCheck;
          end
        end
        StCheck: begin
          if (escape) begin
            // Escape of z_k leaves iter_count at k.
            escaped <= 1'b1;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            x_q        <= x_next;
            y_q        <= y_next;
            iter_count <= iter_inc;
            if (iter_inc == max_q) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              mult_a      <= x_next;
              mult_b      <= x_next;
              mult_in_val <= 1'b1;
              state_q     <= StReqXx;
            end
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
